// File: rtl/regfile_fib_ctrl.sv
// rtl/regfile_fib_ctrl.sv - master FSM that fills a single-read/single-write regfile with a Fibonacci-style sequence
//
// Ports:
//   clk      in   1         rising-edge clock
//   rst_n    in   1         asynchronous active-low reset
//   start    in   1         run request, only honoured in IDLE
//   f0, f1   in   DATA_W    seeds for entries 0 and 1, captured on accepted start
//   n_terms  in   ADDR_W+1  number of entries to fill, clamped to [2, DEPTH] on capture
//   rAddr1   out  ADDR_W    regfile read address
//   rDout1   in   DATA_W    regfile read data (combinational from rAddr1)
//   wAddr    out  ADDR_W    regfile write address
//   wDin     out  DATA_W    regfile write data
//   wEna     out  1         regfile write enable
//   busy     out  1         high in every state except IDLE and DONE
//   done     out  1         one-cycle pulse in DONE
//   result   out  DATA_W    last value written, held until the next run overwrites it
//   ovf      out  1         sticky carry-out flag for the current run
module regfile_fib_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] f0,
    input  logic [DATA_W-1:0] f1,
    input  logic [ADDR_W:0]   n_terms,
    output logic [ADDR_W-1:0] rAddr1,
    input  logic [DATA_W-1:0] rDout1,
    output logic [ADDR_W-1:0] wAddr,
    output logic [DATA_W-1:0] wDin,
    output logic              wEna,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              ovf
);

    typedef enum logic [2:0] {
        IDLE,
        INIT0,
        INIT1,
        RD_A,
        RD_B,
        WR,
        DONE
    } state_t;

    localparam logic [ADDR_W:0] NMIN = (ADDR_W+1)'(2);
    localparam logic [ADDR_W:0] NMAX = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

    state_t            state;
    state_t            stateNext;
    logic [DATA_W-1:0] f0Reg;
    logic [DATA_W-1:0] f1Reg;
    logic [DATA_W-1:0] aReg;
    logic [DATA_W-1:0] sReg;
    logic [ADDR_W:0]   nReg;
    logic [ADDR_W:0]   iReg;
    logic [ADDR_W:0]   nClamped;
    logic [ADDR_W:0]   iMinus1;
    logic [ADDR_W:0]   iMinus2;
    logic [ADDR_W:0]   nMinus1;
    logic [DATA_W:0]   sum;

    assign nClamped = (n_terms < NMIN) ? NMIN : ((n_terms > NMAX) ? NMAX : n_terms);
    assign iMinus1  = iReg - ONE;
    assign iMinus2  = iReg - NMIN;
    assign nMinus1  = nReg - ONE;
    // One extra bit on the adder exposes the carry for the sticky overflow flag.
    assign sum      = {1'b0, aReg} + {1'b0, rDout1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            f0Reg  <= '0;
            f1Reg  <= '0;
            aReg   <= '0;
            sReg   <= '0;
            nReg   <= NMIN;
            iReg   <= NMIN;
            result <= '0;
            ovf    <= 1'b0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: begin
                    if (start) begin
                        f0Reg <= f0;
                        f1Reg <= f1;
                        nReg  <= nClamped;
                        iReg  <= NMIN;
                        ovf   <= 1'b0;
                    end
                end
                INIT1: result <= f1Reg;
                RD_A:  aReg <= rDout1;
                RD_B: begin
                    sReg <= sum[DATA_W-1:0];
                    ovf  <= ovf | sum[DATA_W];
                end
                WR: begin
                    result <= sReg;
                    iReg   <= iReg + ONE;
                end
                default: ;
            endcase
        end
    end

    // Outputs depend only on state and registers; the regfile write of one
    // term commits on the WR edge, so the next RD_A already sees it.
    always_comb begin
        stateNext = state;
        rAddr1    = '0;
        wAddr     = '0;
        wDin      = '0;
        wEna      = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    stateNext = INIT0;
                end
            end
            INIT0: begin
                wEna      = 1'b1;
                wAddr     = '0;
                wDin      = f0Reg;
                stateNext = INIT1;
            end
            INIT1: begin
                wEna      = 1'b1;
                wAddr     = ADDR_W'(1);
                wDin      = f1Reg;
                stateNext = (nReg == NMIN) ? DONE : RD_A;
            end
            RD_A: begin
                rAddr1    = iMinus2[ADDR_W-1:0];
                stateNext = RD_B;
            end
            RD_B: begin
                rAddr1    = iMinus1[ADDR_W-1:0];
                stateNext = WR;
            end
            WR: begin
                wEna      = 1'b1;
                wAddr     = iReg[ADDR_W-1:0];
                wDin      = sReg;
                stateNext = (iReg == nMinus1) ? DONE : RD_A;
            end
            DONE: begin
                busy      = 1'b0;
                done      = 1'b1;
                stateNext = IDLE;
            end
            default: begin
                busy      = 1'b0;
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_fib_ctrl.sv
// tb/tb_regfile_fib_ctrl.sv - self-checking bench for regfile_fib_ctrl with a behavioural regfile
module tb_regfile_fib_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] f0 = '0;
    logic [31:0] f1 = '0;
    logic [6:0]  n_terms = '0;
    logic [5:0]  rAddr1;
    logic [31:0] rDout1;
    logic [5:0]  wAddr;
    logic [31:0] wDin;
    logic        wEna;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        ovf;

    logic [31:0] mem [0:63];
    logic [5:0]  wa [$];
    logic [31:0] wd [$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    regfile_fib_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .f0(f0), .f1(f1), .n_terms(n_terms),
        .rAddr1(rAddr1), .rDout1(rDout1), .wAddr(wAddr), .wDin(wDin), .wEna(wEna),
        .busy(busy), .done(done), .result(result), .ovf(ovf)
    );

    assign rDout1 = mem[rAddr1];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && wEna) begin
            mem[wAddr] <= wDin;
            wa.push_back(wAddr);
            wd.push_back(wDin);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic runCase(input logic [31:0] a, input logic [31:0] b, input int nv, input int againAt);
        int          nEff;
        int          expLat;
        int          lat;
        int          t0;
        logic [31:0] ex [$];
        logic        expOvf;
        logic [32:0] s;
        nEff = (nv < 2) ? 2 : ((nv > 64) ? 64 : nv);
        ex.push_back(a);
        ex.push_back(b);
        expOvf = 1'b0;
        for (int k = 2; k < nEff; k++) begin
            s = {1'b0, ex[k-1]} + {1'b0, ex[k-2]};
            expOvf |= s[32];
            ex.push_back(s[31:0]);
        end
        expLat = 2 + 3 * (nEff - 2);

        @(negedge clk);
        wa.delete();
        wd.delete();
        f0 = a;
        f1 = b;
        n_terms = 7'(nv);
        start = 1'b1;
        @(negedge clk);
        t0 = cyc;
        start = 1'b0;
        f0 = $urandom;
        f1 = $urandom;
        n_terms = 7'($urandom_range(0, 127));
        chk("busy_after_start", 64'(busy), 64'(1));

        lat = -1;
        for (int k = 0; k < 400; k++) begin
            if (done) begin
                lat = cyc - t0;
                break;
            end
            start = (againAt > 0) && (cyc - t0 == againAt - 1);
            @(negedge clk);
        end
        start = 1'b0;

        chk("done_latency", 64'(lat), 64'(expLat));
        chk("write_count", 64'(wa.size()), 64'(nEff));
        for (int k = 0; k < nEff && k < wa.size(); k++) begin
            chk($sformatf("waddr[%0d]", k), 64'(wa[k]), 64'(k));
            chk($sformatf("wdata[%0d]", k), 64'(wd[k]), 64'(ex[k]));
            chk($sformatf("mem[%0d]", k), 64'(mem[k]), 64'(ex[k]));
        end
        chk("result", 64'(result), 64'(ex[nEff-1]));
        chk("ovf", 64'(ovf), 64'(expOvf));
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'(0));
        chk("idle_not_busy", 64'(busy), 64'(0));
    endtask

    task automatic checkAllZero(input string pfx);
        chk({pfx, "_wEna"}, 64'(wEna), 64'(0));
        chk({pfx, "_busy"}, 64'(busy), 64'(0));
        chk({pfx, "_done"}, 64'(done), 64'(0));
        chk({pfx, "_result"}, 64'(result), 64'(0));
        chk({pfx, "_ovf"}, 64'(ovf), 64'(0));
        chk({pfx, "_wAddr"}, 64'(wAddr), 64'(0));
        chk({pfx, "_wDin"}, 64'(wDin), 64'(0));
        chk({pfx, "_rAddr1"}, 64'(rAddr1), 64'(0));
    endtask

    initial begin
        int t0;
        #1;
        checkAllZero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        runCase(32'd1, 32'd1, 8, 0);
        runCase(32'd5, 32'd9, 2, 0);
        runCase(32'd5, 32'd9, 0, 0);
        runCase(32'h8000_0000, 32'h8000_0000, 3, 0);
        runCase(32'd2, 32'd3, 5, 0);
        runCase(32'd0, 32'd1, 100, 0);
        runCase(32'd1, 32'd1, 8, 7);

        // Asynchronous reset in the middle of a run (state WR after edge T+10).
        @(negedge clk);
        f0 = 32'd3;
        f1 = 32'd4;
        n_terms = 7'd20;
        start = 1'b1;
        @(negedge clk);
        t0 = cyc;
        start = 1'b0;
        for (int k = 0; k < 20 && (cyc - t0) < 10; k++) @(negedge clk);
        chk("pre_reset_wEna", 64'(wEna), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("midreset");
        @(negedge clk);
        chk("reset_held_busy", 64'(busy), 64'(0));
        rst_n = 1'b1;
        chk("kept_mem2", 64'(mem[2]), 64'(7));
        chk("kept_mem3", 64'(mem[3]), 64'(11));
        runCase(32'd1, 32'd2, 6, 0);

        for (int r = 0; r < 6; r++) begin
            runCase($urandom, $urandom, int'($urandom_range(0, 70)), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
